// File: rtl/pe_pending_encoder_if.sv
// Request/issue bus of the pending-request priority encoder.
//   master : request/control side (drives io_en, io_in, io_mode, io_flush, io_ready)
//   slave  : encoder side (drives io_valid, io_out, io_drop, wb_eno, wb_gs)
// Signals:
//   io_en     block enable, gates capture and issue
//   io_in     request lines, one per index
//   io_mode   0 = fixed priority (highest index), 1 = round-robin
//   io_flush  synchronous clear of pending bits and output stage
//   io_ready  consumer accepts io_out this cycle
//   io_valid  io_out holds an issued index
//   io_out    issued request index
//   io_drop   registered pulse: a request hit an already-pending line
//   wb_eno    cascade enable-out: enabled and completely idle
//   wb_gs     group select: enabled and holding a valid index
interface pe_pending_encoder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
);

  logic             io_en;
  logic [WIDTH-1:0] io_in;
  logic             io_mode;
  logic             io_flush;
  logic             io_ready;
  logic             io_valid;
  logic [IDXW-1:0]  io_out;
  logic             io_drop;
  logic             wb_eno;
  logic             wb_gs;

  modport master (
    output io_en, io_in, io_mode, io_flush, io_ready,
    input  io_valid, io_out, io_drop, wb_eno, wb_gs
  );

  modport slave (
    input  io_en, io_in, io_mode, io_flush, io_ready,
    output io_valid, io_out, io_drop, wb_eno, wb_gs
  );

endinterface

// File: rtl/pe_pending_encoder.sv
// Registered pending-request priority encoder.
// Request lines are OR-ed into a sticky pending register; one pending index
// at a time is issued on a valid/ready output stage, chosen either by fixed
// priority (highest index wins) or round-robin starting below the last
// issued index.
// Ports:
//   wb_clk_i  clock, rising edge
//   wb_rst_n  synchronous active-low reset
//   bus       pe_pending_encoder_if.slave (request inputs, issue outputs,
//             drop pulse, cascade enable-out and group select)
module pe_pending_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  pe_pending_encoder_if.slave   bus
);

  // Registered state
  logic [WIDTH-1:0] pend_q;
  logic             valid_q;
  logic [IDXW-1:0]  out_q;
  logic [IDXW-1:0]  ptr_q;
  logic             drop_q;

  // Combinational next-state helpers
  logic [IDXW-1:0]  fix_idx;
  logic [IDXW-1:0]  rr_idx;
  logic [IDXW-1:0]  sel_idx;
  logic             load_c;
  logic [WIDTH-1:0] loadmask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] pend_nxt;
  logic             drop_nxt;

  // Index reached k steps below p with wrap-around (1 <= k <= WIDTH).
  function automatic logic [IDXW-1:0] rr_pos(input logic [IDXW-1:0] p,
                                             input int unsigned k);
    int unsigned t;
    t = (32'(p) + WIDTH - k) % WIDTH;
    return IDXW'(t);
  endfunction

  // Fixed priority: last hit of an ascending scan is the highest set bit.
  always_comb begin
    fix_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) fix_idx = IDXW'(i);
    end
  end

  // Round-robin: scan from the far end of the order (k = WIDTH, i.e. ptr
  // itself) toward k = 1 (ptr-1) so the last hit is the nearest below ptr.
  always_comb begin
    rr_idx = '0;
    for (int unsigned k = WIDTH; k >= 1; k--) begin
      if (pend_q[rr_pos(ptr_q, k)]) rr_idx = rr_pos(ptr_q, k);
    end
  end

  // Issue decision and pending-register update.
  always_comb begin
    sel_idx  = bus.io_mode ? rr_idx : fix_idx;
    load_c   = bus.io_en & (|pend_q) & (~valid_q | bus.io_ready);
    loadmask = load_c ? (WIDTH'(1) << sel_idx) : '0;
    capture  = bus.io_en ? bus.io_in : '0;
    // OR-ing capture after clearing lets a re-request win over the load clear.
    pend_nxt = (pend_q & ~loadmask) | capture;
    drop_nxt = bus.io_en & (|(bus.io_in & pend_q & ~loadmask));
  end

  // State update: reset, then flush, then normal capture/issue.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else if (bus.io_flush) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      drop_q <= drop_nxt;
      if (load_c) begin
        out_q   <= sel_idx;
        valid_q <= 1'b1;
        ptr_q   <= sel_idx;
      end else if (valid_q && bus.io_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.io_valid = valid_q;
  assign bus.io_out   = out_q;
  assign bus.io_drop  = drop_q;
  // Cascade outputs depend on registered state and the enable only.
  assign bus.wb_eno   = bus.io_en & ~(|pend_q) & ~valid_q;
  assign bus.wb_gs    = bus.io_en & valid_q;

endmodule

// File: tb/tb_pe_pending_encoder.sv
// Bench for pe_pending_encoder (WIDTH=8): directed scenarios with an issue
// scoreboard, followed by a random phase compared against a cycle model.
module tb_pe_pending_encoder;

  logic clk = 1'b0;
  logic rst_n;

  pe_pending_encoder_if #(.WIDTH(8)) bus ();

  pe_pending_encoder #(.WIDTH(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int exp_q[$];
  bit sb_on   = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_vo(input string tag, input bit v, input int o);
    check({tag, "_valid"}, int'(bus.io_valid), int'(v));
    if (v) check({tag, "_out"}, int'(bus.io_out), o);
  endtask

  // Scoreboard: pop one expected index per accepted transfer.
  always @(negedge clk) begin
    if (sb_on && rst_n && !bus.io_flush && bus.io_valid && bus.io_ready) begin
      check("sb_has_exp", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_idx", int'(bus.io_out), exp_q.pop_front());
    end
  end

  // Cycle model of the encoder used in the random phase.
  logic [7:0] m_p;
  logic       m_v;
  logic [2:0] m_o;
  logic [2:0] m_ptr;
  logic       m_d;
  logic [7:0] m_lm;
  int         m_s;
  int         m_j;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p <= '0; m_v <= 1'b0; m_o <= '0; m_ptr <= '0; m_d <= 1'b0;
    end else if (bus.io_flush) begin
      m_p <= '0; m_v <= 1'b0; m_d <= 1'b0;
    end else begin
      m_lm = '0;
      m_s  = -1;
      if (bus.io_en && m_p != 0 && (!m_v || bus.io_ready)) begin
        if (!bus.io_mode) begin
          for (int i = 0; i < 8; i++) if (m_p[i]) m_s = i;
        end else begin
          for (int k = 1; k <= 8; k++) begin
            m_j = (int'(m_ptr) - k + 8) % 8;
            if (m_s < 0 && m_p[m_j]) m_s = m_j;
          end
        end
        m_lm[m_s] = 1'b1;
        m_o   <= 3'(m_s);
        m_ptr <= 3'(m_s);
        m_v   <= 1'b1;
      end else if (m_v && bus.io_ready) begin
        m_v <= 1'b0;
      end
      m_p <= (m_p & ~m_lm) | (bus.io_en ? bus.io_in : 8'h00);
      m_d <= bus.io_en && ((bus.io_in & m_p & ~m_lm) != 0);
    end
  end

  initial begin
    int rr_seq[5];
    rr_seq = '{7, 1, 0, 7, 1};

    rst_n = 1'b0;
    bus.io_en = 1'b0; bus.io_in = '0; bus.io_mode = 1'b0;
    bus.io_flush = 1'b0; bus.io_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    exp_vo("rst", 1'b0, 0);
    check("rst_out", int'(bus.io_out), 0);
    check("rst_drop", int'(bus.io_drop), 0);
    check("rst_gs", int'(bus.wb_gs), 0);
    check("rst_eno_dis", int'(bus.wb_eno), 0);
    rst_n = 1'b1; bus.io_en = 1'b1; bus.io_ready = 1'b1;
    #1;
    check("idle_eno", int'(bus.wb_eno), 1);

    // Fixed priority, single-cycle request 0010_0101
    bus.io_in = 8'h25;
    exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
    tick(); bus.io_in = 8'h00;
    exp_vo("fix_lat", 1'b0, 0);
    tick(); exp_vo("fix0", 1'b1, 5);
    check("fix_gs", int'(bus.wb_gs), 1);
    check("fix_eno", int'(bus.wb_eno), 0);
    tick(); exp_vo("fix1", 1'b1, 2);
    tick(); exp_vo("fix2", 1'b1, 0);
    tick(); exp_vo("fix_end", 1'b0, 0);
    check("fix_end_eno", int'(bus.wb_eno), 1);
    check("fix_end_drop", int'(bus.io_drop), 0);

    // Round-robin with held 1000_0011
    bus.io_mode = 1'b1; bus.io_in = 8'h83;
    foreach (rr_seq[i]) exp_q.push_back(rr_seq[i]);
    exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(1);
    tick(); exp_vo("rr_cap", 1'b0, 0);
    check("rr_cap_drop", int'(bus.io_drop), 0);
    for (int i = 0; i < 5; i++) begin
      tick(); exp_vo("rr", 1'b1, rr_seq[i]);
      check("rr_drop", int'(bus.io_drop), 1);
    end
    bus.io_in = 8'h00;
    tick(); exp_vo("rr_rel0", 1'b1, 0);
    check("rr_rel_drop", int'(bus.io_drop), 0);
    tick(); exp_vo("rr_rel1", 1'b1, 7);
    tick(); exp_vo("rr_rel2", 1'b1, 1);
    tick(); exp_vo("rr_end", 1'b0, 0);

    // Backpressure with pending 0000_1100
    bus.io_mode = 1'b0; bus.io_ready = 1'b0; bus.io_in = 8'h0C;
    exp_q.push_back(3); exp_q.push_back(2);
    tick(); bus.io_in = 8'h00;
    exp_vo("bp_lat", 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); exp_vo("bp_hold", 1'b1, 3);
      check("bp_gs", int'(bus.wb_gs), 1);
    end
    bus.io_ready = 1'b1;
    tick(); exp_vo("bp_next", 1'b1, 2);
    bus.io_ready = 1'b0;
    tick(); exp_vo("bp_next_hold", 1'b1, 2);
    bus.io_ready = 1'b1;
    tick(); exp_vo("bp_end", 1'b0, 0);

    // Set wins over clear on bit 4
    bus.io_in = 8'h10;
    exp_q.push_back(4); exp_q.push_back(4);
    tick(); exp_vo("sw_cap", 1'b0, 0);
    tick(); bus.io_in = 8'h00;
    exp_vo("sw0", 1'b1, 4);
    check("sw0_drop", int'(bus.io_drop), 0);
    tick(); exp_vo("sw1", 1'b1, 4);
    check("sw1_drop", int'(bus.io_drop), 0);
    tick(); exp_vo("sw_end", 1'b0, 0);
    check("sw_end_eno", int'(bus.wb_eno), 1);

    // io_en=0 with a valid index and pending bits
    bus.io_ready = 1'b0; bus.io_in = 8'h0E;
    exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1);
    tick(); bus.io_in = 8'h00;
    tick(); exp_vo("en_setup", 1'b1, 3);
    bus.io_en = 1'b0; bus.io_ready = 1'b1; bus.io_in = 8'h01;
    #1;
    check("en_off_gs", int'(bus.wb_gs), 0);
    check("en_off_eno", int'(bus.wb_eno), 0);
    tick(); exp_vo("en_off", 1'b0, 0);
    check("en_off_out_hold", int'(bus.io_out), 3);
    check("en_off_eno2", int'(bus.wb_eno), 0);
    check("en_off_gs2", int'(bus.wb_gs), 0);
    check("en_off_drop", int'(bus.io_drop), 0);
    tick(); exp_vo("en_off_noload", 1'b0, 0);
    bus.io_en = 1'b1; bus.io_in = 8'h00;
    tick(); exp_vo("en_on0", 1'b1, 2);
    tick(); exp_vo("en_on1", 1'b1, 1);
    tick(); exp_vo("en_end", 1'b0, 0);
    check("en_end_eno", int'(bus.wb_eno), 1);

    // Flush mid-handshake, pointer retained
    bus.io_mode = 1'b1; bus.io_ready = 1'b0; bus.io_in = 8'hF0;
    tick(); bus.io_in = 8'h00;
    tick(); exp_vo("fl_setup", 1'b1, 7);
    bus.io_flush = 1'b1; bus.io_in = 8'hF0;
    tick(); exp_vo("fl", 1'b0, 0);
    check("fl_drop", int'(bus.io_drop), 0);
    check("fl_eno", int'(bus.wb_eno), 1);
    bus.io_flush = 1'b0; bus.io_in = 8'h81; bus.io_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(7);
    tick(); bus.io_in = 8'h00;
    tick(); exp_vo("fl_ptr0", 1'b1, 0);
    tick(); exp_vo("fl_ptr1", 1'b1, 7);
    tick(); exp_vo("fl_end", 1'b0, 0);

    // Reset mid-handshake, pointer cleared
    bus.io_ready = 1'b0; bus.io_in = 8'hF0;
    tick(); bus.io_in = 8'h00;
    tick(); exp_vo("rs_setup", 1'b1, 6);
    rst_n = 1'b0; bus.io_in = 8'hF0;
    tick(); exp_vo("rs", 1'b0, 0);
    check("rs_out", int'(bus.io_out), 0);
    check("rs_drop", int'(bus.io_drop), 0);
    check("rs_eno", int'(bus.wb_eno), 1);
    rst_n = 1'b1; bus.io_in = 8'h81; bus.io_ready = 1'b1;
    exp_q.push_back(7); exp_q.push_back(0);
    tick(); bus.io_in = 8'h00;
    tick(); exp_vo("rs_ptr0", 1'b1, 7);
    tick(); exp_vo("rs_ptr1", 1'b1, 0);
    tick(); exp_vo("rs_end", 1'b0, 0);
    check("sb_empty", exp_q.size(), 0);

    // Random traffic against the cycle model
    sb_on = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      bus.io_en    = ($urandom_range(0, 7) != 0);
      bus.io_in    = 8'($urandom & $urandom & $urandom);
      bus.io_mode  = 1'($urandom_range(0, 1));
      bus.io_ready = ($urandom_range(0, 3) != 0);
      bus.io_flush = ($urandom_range(0, 31) == 0);
      tick();
      exp_vo("rnd", m_v, int'(m_o));
      check("rnd_known", int'(!$isunknown(bus.io_out)), 1);
      check("rnd_drop", int'(bus.io_drop), int'(m_d));
      check("rnd_eno", int'(bus.wb_eno), int'(bus.io_en && m_p == 0 && !m_v));
      check("rnd_gs", int'(bus.wb_gs), int'(bus.io_en && m_v));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
